// File: rtl/wb_arb2_wdt.sv
// rtl/wb_arb2_wdt.sv - Two-master Wishbone classic arbiter with round-robin grant and bus watchdog
module wb_arb2_wdt #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,

    output logic [1:0]      grant_o,
    output logic            bus_err_o
);

    localparam bit WDT_EN = (TIMEOUT > 0);
    localparam int WDT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = (TIMEOUT > 0) ? WDT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              last, last_nxt;
    logic [WDT_W-1:0]  wdt, wdt_nxt;
    logic              bus_err_q;

    logic              g0, g1;
    logic              gcyc, gstb;
    logic              term, expire;

    assign g0 = (state == GNT0);
    assign g1 = (state == GNT1);

    // Request mux: everything toward the slave is zero while idle.
    always_comb begin
        gcyc    = 1'b0;
        gstb    = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        if (g0) begin
            gcyc    = m0_cyc_i;
            gstb    = m0_stb_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_cti_o = m0_cti_i;
            s_bte_o = m0_bte_i;
        end else if (g1) begin
            gcyc    = m1_cyc_i;
            gstb    = m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_cti_o = m1_cti_i;
            s_bte_o = m1_bte_i;
        end
    end

    // A slave termination in the expiry cycle takes priority over the watchdog.
    assign term   = s_ack_i | s_err_i | s_rty_i;
    assign expire = WDT_EN && (g0 || g1) && gstb && !term && (wdt == WDT_LAST);

    assign s_cyc_o = gcyc & ~expire;
    assign s_stb_o = gstb & ~expire;

    assign m0_dat_o = g0 ? s_dat_i : '0;
    assign m0_ack_o = g0 & s_ack_i;
    assign m0_err_o = g0 & (s_err_i | expire);
    assign m0_rty_o = g0 & s_rty_i;

    assign m1_dat_o = g1 ? s_dat_i : '0;
    assign m1_ack_o = g1 & s_ack_i;
    assign m1_err_o = g1 & (s_err_i | expire);
    assign m1_rty_o = g1 & s_rty_i;

    assign grant_o   = {g1, g0};
    assign bus_err_o = bus_err_q;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_nxt = GNT0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_nxt  = 1'b0;
                    state_nxt = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_nxt  = 1'b1;
                    state_nxt = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wdt_nxt = '0;
        if (WDT_EN && (g0 || g1) && gstb && !term && !expire) begin
            wdt_nxt = wdt + WDT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= IDLE;
            last      <= 1'b1;
            wdt       <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            wdt       <= wdt_nxt;
            bus_err_q <= expire;
        end
    end

endmodule

// File: tb/tb_wb_arb2_wdt.sv
// tb/tb_wb_arb2_wdt.sv - Self-checking bench for wb_arb2_wdt with an ack-order scoreboard
module tb_wb_arb2_wdt;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_dat;
    logic [SW-1:0] m0_sel;
    logic [2:0]    m0_cti;
    logic [1:0]    m0_bte;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o;

    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_dat;
    logic [SW-1:0] m1_sel;
    logic [2:0]    m1_cti;
    logic [1:0]    m1_bte;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o, m1_rty_o;

    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic [2:0]    s_cti_o;
    logic [1:0]    s_bte_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i, s_rty_i;
    logic [1:0]    grant_o;
    logic          bus_err_o;

    logic slv_auto, slv_force_ack;

    typedef struct packed {
        logic        m;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    wb_arb2_wdt #(.DW(DW), .AW(AW), .TIMEOUT(4)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o), .bus_err_o(bus_err_o)
    );

    // Slave model: acks off the bench's own request view so there is no loop through the DUT.
    assign s_err_i = 1'b0;
    assign s_rty_i = 1'b0;
    always_comb begin
        s_ack_i = slv_force_ack ||
                  (slv_auto && ((grant_o[0] && m0_cyc && m0_stb) || (grant_o[1] && m1_cyc && m1_stb)));
        s_dat_i = (s_adr_o == 32'h10) ? 32'hDEADBEEF : ~s_adr_o;
    end

    task automatic idle_masters();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_cti = '0; m0_bte = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_cti = '0; m1_bte = '0;
    endtask

    task automatic test_reset();
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20;
        slv_auto = 1;
        sb.push_back({1'b0, 32'hDEADBEEF});
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b expected 00", grant_o); end
        n_checks++; if ({s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_rty_o, bus_err_o} !== 6'b0) begin
            n_fail++; $display("FAIL rst_outputs: got %b expected 000000", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_rty_o, bus_err_o}); end
        n_checks++; if (m0_dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_m0_dat: got %h expected 0", m0_dat_o); end
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL arb_latency: got %b expected 00", grant_o); end
        seen = 0;
        for (int t = 0; t < 4 && !seen; t++) begin
            @(negedge clk);
            n_checks++; if (m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL m1_ack_leak: got %b expected 0", m1_ack_o); end
            if (m0_ack_o === 1'b1) begin
                seen = 1;
                e = sb.pop_front();
                n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL first_grant: got %b expected 01", grant_o); end
                n_checks++; if (m0_dat_o !== e.d) begin n_fail++; $display("FAIL m0_read: got %h expected %h", m0_dat_o, e.d); end
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL m0_read_timeout: got no ack expected ack"); end
    endtask

    task automatic test_handover();
        exp_t e;
        sb.push_back({1'b1, ~32'h40});
        @(posedge clk); #1;
        m0_cyc = 0; m0_stb = 0;
        m1_we = 1; m1_adr = 32'h40; m1_dat = 32'h12345678; m1_sel = 4'hF; m1_cti = 3'b111; m1_bte = 2'b01;
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b01 || s_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL handover_pre: got grant %b cyc %b expected 01/0", grant_o, s_cyc_o); end
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL handover_grant: got %b expected 10", grant_o); end
        n_checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b111) begin n_fail++; $display("FAIL m1_ctrl: got %b expected 111", {s_cyc_o, s_stb_o, s_we_o}); end
        n_checks++; if (s_dat_o !== 32'h12345678 || s_sel_o !== 4'hF || s_adr_o !== 32'h40) begin
            n_fail++; $display("FAIL m1_write: got %h/%h/%h expected 12345678/f/40", s_dat_o, s_sel_o, s_adr_o); end
        n_checks++; if (s_cti_o !== 3'b111 || s_bte_o !== 2'b01) begin
            n_fail++; $display("FAIL m1_tags: got %b/%b expected 111/01", s_cti_o, s_bte_o); end
        n_checks++; if (m0_ack_o !== 1'b0 || m0_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL m0_isolated: got ack %b dat %h expected 0/0", m0_ack_o, m0_dat_o); end
        if (m1_ack_o === 1'b1) begin
            e = sb.pop_front();
            n_checks++; if (m1_dat_o !== e.d) begin n_fail++; $display("FAIL m1_ack_data: got %h expected %h", m1_dat_o, e.d); end
        end else begin
            n_checks++; n_fail++; $display("FAIL m1_write_ack: got 0 expected 1");
            sb.delete();
        end
        @(posedge clk); #1;
        idle_masters();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   seen, acks0, acks1;
        seen = 0; acks0 = 0; acks1 = 0;
        for (int k = 0; k < 4; k++) begin
            sb.push_back({1'b0, ~(32'h100 + 32'(k * 4))});
            sb.push_back({1'b1, ~(32'h200 + 32'(k * 4))});
        end
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    int t;
                    @(posedge clk); #1;
                    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100 + 32'(k * 4);
                    t = 0;
                    do begin @(negedge clk); t++; end while (m0_ack_o !== 1'b1 && t < 40);
                    @(posedge clk); #1;
                    m0_cyc = 0; m0_stb = 0;
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    int t;
                    @(posedge clk); #1;
                    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200 + 32'(k * 4);
                    t = 0;
                    do begin @(negedge clk); t++; end while (m1_ack_o !== 1'b1 && t < 40);
                    @(posedge clk); #1;
                    m1_cyc = 0; m1_stb = 0;
                end
            end
            begin
                for (int t = 0; t < 300 && seen < 8; t++) begin
                    @(negedge clk);
                    if (m0_ack_o === 1'b1 || m1_ack_o === 1'b1) begin
                        e = sb.pop_front();
                        seen++;
                        if (m0_ack_o === 1'b1) acks0++; else acks1++;
                        n_checks++;
                        if (m1_ack_o !== e.m || m0_ack_o === m1_ack_o || grant_o !== (e.m ? 2'b10 : 2'b01) ||
                            (e.m ? m1_dat_o : m0_dat_o) !== e.d) begin
                            n_fail++;
                            $display("FAIL rr_order txn %0d: got acks %b%b grant %b dat %h expected m%0d dat %h",
                                     seen, m1_ack_o, m0_ack_o, grant_o, (e.m ? m1_dat_o : m0_dat_o), e.m, e.d);
                        end
                    end
                end
            end
        join
        n_checks++; if (seen != 8) begin n_fail++; $display("FAIL rr_count: got %0d expected 8", seen); end
        n_checks++; if (acks0 != 4 || acks1 != 4) begin n_fail++; $display("FAIL rr_starve: got %0d/%0d expected 4/4", acks0, acks1); end
        sb.delete();
        idle_masters();
        repeat (3) @(posedge clk);
    endtask

    task automatic test_wdt_expire();
        int stb_cycles;
        bit got;
        slv_auto = 0; stb_cycles = 0; got = 0;
        @(posedge clk); #1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h80;
        for (int t = 0; t < 12 && !got; t++) begin
            @(negedge clk);
            if (grant_o === 2'b01) stb_cycles++;
            if (m0_err_o === 1'b1) begin
                got = 1;
                n_checks++; if (stb_cycles != 4) begin n_fail++; $display("FAIL wdt_when: got err at stb cycle %0d expected 4", stb_cycles); end
                n_checks++; if (s_stb_o !== 1'b0 || s_cyc_o !== 1'b0) begin
                    n_fail++; $display("FAIL wdt_force: got cyc %b stb %b expected 0/0", s_cyc_o, s_stb_o); end
                n_checks++; if (bus_err_o !== 1'b0 || m1_err_o !== 1'b0) begin
                    n_fail++; $display("FAIL wdt_early: got bus_err %b m1_err %b expected 0/0", bus_err_o, m1_err_o); end
            end
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL wdt_timeout: got no err expected err"); end
        @(negedge clk);
        n_checks++; if (bus_err_o !== 1'b1) begin n_fail++; $display("FAIL bus_err_pulse: got %b expected 1", bus_err_o); end
        n_checks++; if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
            n_fail++; $display("FAIL wdt_rearm: got err %b stb %b expected 0/1", m0_err_o, s_stb_o); end
        @(posedge clk); #1;
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        n_checks++; if (bus_err_o !== 1'b0) begin n_fail++; $display("FAIL bus_err_width: got %b expected 0", bus_err_o); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_wdt_ack4();
        exp_t e;
        int   t;
        slv_auto = 0;
        sb.push_back({1'b0, ~32'h84});
        @(posedge clk); #1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h84;
        t = 0;
        do begin @(negedge clk); t++; end while (grant_o !== 2'b01 && t < 10);
        repeat (3) @(posedge clk);
        #1 slv_force_ack = 1;
        @(negedge clk);
        n_checks++; if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0) begin
            n_fail++; $display("FAIL ack4_term: got ack %b err %b expected 1/0", m0_ack_o, m0_err_o); end
        n_checks++; if (s_stb_o !== 1'b1) begin n_fail++; $display("FAIL ack4_stb: got %b expected 1", s_stb_o); end
        e = sb.pop_front();
        n_checks++; if (m0_dat_o !== e.d) begin n_fail++; $display("FAIL ack4_data: got %h expected %h", m0_dat_o, e.d); end
        @(posedge clk); #1;
        slv_force_ack = 0; m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        n_checks++; if (bus_err_o !== 1'b0) begin n_fail++; $display("FAIL ack4_bus_err: got %b expected 0", bus_err_o); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_midburst();
        int t;
        slv_auto = 1;
        @(posedge clk); #1;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300; m1_cti = 3'b010;
        t = 0;
        do begin @(negedge clk); t++; end while (grant_o !== 2'b10 && t < 10);
        @(negedge clk);
        n_checks++; if (s_cyc_o !== 1'b1 || m1_ack_o !== 1'b1) begin
            n_fail++; $display("FAIL burst_active: got cyc %b ack %b expected 1/1", s_cyc_o, m1_ack_o); end
        #2 rst_n = 0;
        #1;
        n_checks++; if (s_cyc_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got cyc %b ack %b expected 0/0", s_cyc_o, m1_ack_o); end
        n_checks++; if (grant_o !== 2'b00 || m1_dat_o !== 32'h0 || m1_rty_o !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_grant: got %b dat %h rty %b expected 00/0/0", grant_o, m1_dat_o, m1_rty_o); end
        idle_masters();
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle %0d: got %b expected 00", k, grant_o); end
        end
        @(posedge clk); #1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL post_reset_grant: got %b expected 01", grant_o); end
        @(posedge clk); #1;
        idle_masters();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        idle_masters();
        slv_auto = 0;
        slv_force_ack = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        test_reset();
        test_handover();
        test_round_robin();
        test_wdt_expire();
        test_wdt_ack4();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
